mc_sequencer: RTL

- Multicycle control FSM that sequences the single-bus CPU datapath: PC/NPC/IR fetch, register/immediate holders, ALU operand muxes, DMEM write and write-back muxing.
- Decodes opcode/func from the IR output and drives every datapath enable, one state per pipeline phase (IF, ID, EX, MEM, WB).
- Adds illegal-opcode halt and a retired-instruction counter for debug.

---
 rtl/mc_pkg.sv | 51 +++++
 rtl/mc_decode.sv | 46 ++++
 rtl/mc_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multicycle CPU sequencer.
//   - opcode constants (IR[31:26]) and R-type func codes (IR[10:0])
//   - ALU operation codes used outside R-type execution
//   - FSM state and instruction-class enumerations, decode result struct
package mc_pkg;

    localparam int FUNC_W = 11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [FUNC_W-1:0] FN_ADD  = 11'h020;
    localparam logic [FUNC_W-1:0] FN_SUB  = 11'h022;
    localparam logic [FUNC_W-1:0] FN_AND  = 11'h024;
    localparam logic [FUNC_W-1:0] FN_OR   = 11'h025;
    localparam logic [FUNC_W-1:0] FN_XOR  = 11'h026;
    localparam logic [FUNC_W-1:0] FN_SLT  = 11'h02A;
    localparam logic [FUNC_W-1:0] FN_MOVZ = 11'h00A;

    // The ALU shares the R-type func encoding, so ADD reuses FN_ADD.
    localparam logic [FUNC_W-1:0] ALU_ADD   = FN_ADD;
    localparam logic [FUNC_W-1:0] ALU_PASSB = 11'h03F;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE = 3'd0,
        CL_LW    = 3'd1,
        CL_SW    = 3'd2,
        CL_BEQ   = 3'd3,
        CL_J     = 3'd4,
        CL_ILL   = 3'd5
    } iclass_t;

    typedef struct packed {
        iclass_t cls;
        logic    legal;
        logic    movz;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
//   i_opcode : IR[31:26]
//   i_func   : IR[10:0]
//   o_dec    : {class, legal, movz}; an unknown opcode or an R-type with an
//              unknown func is reported as CL_ILL / legal=0.
module mc_decode
    import mc_pkg::*;
#(
    parameter int ALU_OP_W = 11
) (
    input  logic [5:0]          i_opcode,
    input  logic [ALU_OP_W-1:0] i_func,
    output dec_t                o_dec
);

    logic w_func_known;

    always_comb begin
        w_func_known = (i_func == ALU_OP_W'(FN_ADD))  ||
                       (i_func == ALU_OP_W'(FN_SUB))  ||
                       (i_func == ALU_OP_W'(FN_AND))  ||
                       (i_func == ALU_OP_W'(FN_OR))   ||
                       (i_func == ALU_OP_W'(FN_XOR))  ||
                       (i_func == ALU_OP_W'(FN_SLT))  ||
                       (i_func == ALU_OP_W'(FN_MOVZ));
    end

    always_comb begin
        o_dec       = '0;
        o_dec.cls   = CL_ILL;
        o_dec.legal = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_dec.cls   = w_func_known ? CL_RTYPE : CL_ILL;
                o_dec.legal = w_func_known;
                o_dec.movz  = (i_func == ALU_OP_W'(FN_MOVZ));
            end
            OP_LW:   o_dec.cls = CL_LW;
            OP_SW:   o_dec.cls = CL_SW;
            OP_BEQ:  o_dec.cls = CL_BEQ;
            OP_J:    o_dec.cls = CL_J;
            default: o_dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control FSM for the single-bus CPU datapath.
//   clk, rst                : clock, asynchronous active-high reset
//   opcode, alu_func        : IR fields (stable from ID onward)
//   equal                   : ALU equality flag, used in EX of BEQ
//   rt                      : register port-2 data, sampled in ID for MOVZ
//   pc/npc/ir enables, pc_select_enable, mux1/mux2 selects, alu_op,
//   reg/mem write enables, writeback/mem_data selects : datapath controls
//   halted                  : sticky, set by an illegal instruction
//   retired_count           : number of cycles with pc_enable=1 (wraps)
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int ALU_OP_W  = 11,
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [ALU_OP_W-1:0]  alu_func,
    input  logic                 equal,
    input  logic [31:0]          rt,
    output logic                 pc_enable,
    output logic                 pc_select_enable,
    output logic                 npc_enable,
    output logic                 ir_enable,
    output logic                 reg_write_enable,
    output logic                 writeback_select_enable,
    output logic                 mux1_select_enable,
    output logic                 mux2_select_enable,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 mem_write_enable,
    output logic                 mem_data_select_enable,
    output logic                 halted,
    output logic [RET_CNT_W-1:0] retired_count
);

    state_t               r_state;
    state_t               w_next;
    logic                 r_movz_ok;
    logic                 r_halted;
    logic [RET_CNT_W-1:0] r_ret;
    dec_t                 w_dec;

    mc_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
        .i_opcode (opcode),
        .i_func   (alu_func),
        .o_dec    (w_dec)
    );

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:   w_next = S_ID;
            S_ID:   w_next = w_dec.legal ? S_EX : S_HALT;
            S_EX: begin
                case (w_dec.cls)
                    CL_RTYPE:     w_next = S_WB;
                    CL_LW, CL_SW: w_next = S_MEM;
                    default:      w_next = S_IF;
                endcase
            end
            S_MEM:  w_next = (w_dec.cls == CL_LW) ? S_WB : S_IF;
            S_WB:   w_next = S_IF;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IF;
            r_movz_ok <= 1'b0;
            r_halted  <= 1'b0;
            r_ret     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) begin
                r_movz_ok <= (rt == '0);
                if (!w_dec.legal) r_halted <= 1'b1;
            end
            if (pc_enable) r_ret <= r_ret + RET_CNT_W'(1);
        end
    end

    // Outputs are gated by rst directly so that a mid-instruction reset
    // kills write enables in the same cycle, before the state register
    // has even been observed.
    always_comb begin
        pc_enable               = 1'b0;
        pc_select_enable        = 1'b0;
        npc_enable              = 1'b0;
        ir_enable               = 1'b0;
        reg_write_enable        = 1'b0;
        writeback_select_enable = 1'b0;
        mux1_select_enable      = 1'b0;
        mux2_select_enable      = 1'b0;
        alu_op                  = '0;
        mem_write_enable        = 1'b0;
        mem_data_select_enable  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IF: begin
                    ir_enable  = 1'b1;
                    npc_enable = 1'b1;
                end
                S_EX: begin
                    case (w_dec.cls)
                        CL_RTYPE: begin
                            mux1_select_enable = 1'b1;
                            alu_op             = alu_func;
                        end
                        CL_LW, CL_SW: begin
                            mux1_select_enable = 1'b1;
                            mux2_select_enable = 1'b1;
                            alu_op             = ALU_OP_W'(ALU_ADD);
                        end
                        CL_BEQ: begin
                            // Branch target = NPC + imm; taken only when equal.
                            mux2_select_enable = 1'b1;
                            alu_op             = ALU_OP_W'(ALU_ADD);
                            pc_enable          = 1'b1;
                            pc_select_enable   = equal;
                        end
                        CL_J: begin
                            mux2_select_enable = 1'b1;
                            alu_op             = ALU_OP_W'(ALU_PASSB);
                            pc_enable          = 1'b1;
                            pc_select_enable   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (w_dec.cls == CL_SW) begin
                        mem_write_enable = 1'b1;
                        pc_enable        = 1'b1;
                    end
                end
                S_WB: begin
                    // MOVZ suppresses the write when rt was nonzero in ID,
                    // but the instruction still retires.
                    reg_write_enable = w_dec.movz ? r_movz_ok : 1'b1;
                    pc_enable        = 1'b1;
                    if (w_dec.cls == CL_LW) writeback_select_enable = 1'b1;
                    else                    mem_data_select_enable  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halted        = r_halted;
    assign retired_count = r_ret;

endmodule
